// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI power-domain types and helpers
package axi_pkg;

    typedef enum logic [2:0] {
        AXI_DOM_ACTIVE  = 3'd0,
        AXI_DOM_DRAIN   = 3'd1,
        AXI_DOM_RSTHOLD = 3'd2,
        AXI_DOM_OFF     = 3'd3,
        AXI_DOM_WAKE    = 3'd4
    } axi_domain_state_e;

    // Largest of three terminal counts; sizes the shared domain counter.
    function automatic int unsigned axi_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/axi_domain_ctrl.sv
// rtl/axi_domain_ctrl.sv - power-domain sequencer: drain, isolate, reset, wake
module axi_domain_ctrl
    import axi_pkg::*;
#(
    parameter int unsigned TimeoutCycles  = 32'd1024,
    parameter int unsigned RstHoldCycles  = 32'd16,
    parameter int unsigned WakeCycles     = 32'd8,
    parameter bit          ForceOnTimeout = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       domain_en_i,
    input  logic       isolated_i,
    output logic       isolate_o,
    output logic       domain_rst_no,
    output logic       active_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam int unsigned CntMax = axi_max3(TimeoutCycles, RstHoldCycles, WakeCycles);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] RstHoldLast = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] WakeLast    = CntW'(WakeCycles - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    // A zero terminal count would make a state unleavable or underflow the compare.
    if (TimeoutCycles == 0) begin : g_bad_timeout
        $fatal(1, "axi_domain_ctrl: TimeoutCycles must be non-zero");
    end
    if (RstHoldCycles == 0) begin : g_bad_rsthold
        $fatal(1, "axi_domain_ctrl: RstHoldCycles must be non-zero");
    end
    if (WakeCycles == 0) begin : g_bad_wake
        $fatal(1, "axi_domain_ctrl: WakeCycles must be non-zero");
    end

    axi_domain_state_e r_state;
    axi_domain_state_e w_state_nxt;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    // State, shared counter and sticky timeout flag; reset parks the domain in Off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= AXI_DOM_OFF;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state and counter rules; one counter serves every timed state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            AXI_DOM_ACTIVE: begin
                if (!domain_en_i) begin
                    w_state_nxt = AXI_DOM_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            AXI_DOM_DRAIN: begin
                // Isolation completing wins over abort and timeout in the same cycle.
                if (isolated_i) begin
                    w_state_nxt = AXI_DOM_RSTHOLD;
                    w_cnt_nxt   = '0;
                end else if (domain_en_i) begin
                    w_state_nxt = AXI_DOM_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TimeoutLast) begin
                    w_timeout_nxt = 1'b1;
                    if (ForceOnTimeout) begin
                        w_state_nxt = AXI_DOM_RSTHOLD;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            AXI_DOM_RSTHOLD: begin
                if (r_cnt == RstHoldLast) begin
                    w_state_nxt = AXI_DOM_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            AXI_DOM_OFF: begin
                if (domain_en_i) begin
                    w_state_nxt   = AXI_DOM_WAKE;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            AXI_DOM_WAKE: begin
                // Losing the request mid-wake re-enters reset hold without visiting Active.
                if (!domain_en_i) begin
                    w_state_nxt = AXI_DOM_RSTHOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == WakeLast) begin
                    w_state_nxt = AXI_DOM_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            default: begin
                w_state_nxt = AXI_DOM_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign isolate_o     = (r_state != AXI_DOM_ACTIVE);
    assign domain_rst_no = (r_state == AXI_DOM_ACTIVE) || (r_state == AXI_DOM_DRAIN) ||
                           (r_state == AXI_DOM_WAKE);
    assign active_o      = (r_state == AXI_DOM_ACTIVE);
    assign timeout_o     = r_timeout;
    assign state_o       = r_state;

endmodule

// File: tb/tb_axi_domain_ctrl.sv
// tb/tb_axi_domain_ctrl.sv - scoreboard bench for axi_domain_ctrl
module tb_axi_domain_ctrl;
    import axi_pkg::*;

    typedef struct {
        int         dut;
        string      tag;
        logic [6:0] exp;
    } sb_item_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] en;
    logic [2:0] iso;
    logic [6:0] obs0, obs1, obs2;

    sb_item_t sb_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    // dut0: defaults; dut1: short timeout, forced; dut2: short timeout, waits forever
    axi_domain_ctrl u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .domain_en_i(en[0]), .isolated_i(iso[0]),
        .isolate_o(obs0[3]), .domain_rst_no(obs0[2]), .active_o(obs0[1]),
        .timeout_o(obs0[0]), .state_o(obs0[6:4])
    );
    axi_domain_ctrl #(.TimeoutCycles(4), .ForceOnTimeout(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .domain_en_i(en[1]), .isolated_i(iso[1]),
        .isolate_o(obs1[3]), .domain_rst_no(obs1[2]), .active_o(obs1[1]),
        .timeout_o(obs1[0]), .state_o(obs1[6:4])
    );
    axi_domain_ctrl #(.TimeoutCycles(4), .ForceOnTimeout(1'b0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .domain_en_i(en[2]), .isolated_i(iso[2]),
        .isolate_o(obs2[3]), .domain_rst_no(obs2[2]), .active_o(obs2[1]),
        .timeout_o(obs2[0]), .state_o(obs2[6:4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] exp_vec(input axi_domain_state_e s, input logic to);
        logic iso_e, rstn_e, act_e;
        iso_e  = (s != AXI_DOM_ACTIVE);
        rstn_e = (s == AXI_DOM_ACTIVE) || (s == AXI_DOM_DRAIN) || (s == AXI_DOM_WAKE);
        act_e  = (s == AXI_DOM_ACTIVE);
        return {s, iso_e, rstn_e, act_e, to};
    endfunction

    function automatic logic [6:0] obs_of(input int d);
        case (d)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    task automatic push(input int d, input string tag, input axi_domain_state_e s, input logic to);
        sb_item_t it;
        it.dut = d;
        it.tag = tag;
        it.exp = exp_vec(s, to);
        sb_q.push_back(it);
    endtask

    task automatic drain_q();
        sb_item_t it;
        logic [6:0] o;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            o  = obs_of(it.dut);
            n_vec++;
            assert (o === it.exp) else begin
                n_fail++;
                $error("FAIL %s dut%0d observed={st,iso,rstn,act,to}=%b expected=%b",
                       it.tag, it.dut, o, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain_q();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 3'b000;
        iso   = 3'b000;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) push(d, "reset", AXI_DOM_OFF, 1'b0);
        drain_q();

        // Wake from reset with the request already high
        en[0] = 1'b1;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(0, "wake_seq", AXI_DOM_WAKE, 1'b0);
            push(1, "idle_off", AXI_DOM_OFF, 1'b0);
            tick();
        end
        push(0, "wake_to_active", AXI_DOM_ACTIVE, 1'b0);
        tick();

        // Normal power-down: drain, isolate after 5 cycles, reset hold, off
        en[0] = 1'b0;
        push(0, "drain_entry", AXI_DOM_DRAIN, 1'b0);
        tick();
        for (int k = 2; k <= 5; k++) begin
            push(0, "drain_wait", AXI_DOM_DRAIN, 1'b0);
            tick();
        end
        iso[0] = 1'b1;
        push(0, "rsthold_entry", AXI_DOM_RSTHOLD, 1'b0);
        tick();
        iso[0] = 1'b0;
        for (int k = 7; k <= 21; k++) begin
            push(0, "rsthold_hold", AXI_DOM_RSTHOLD, 1'b0);
            tick();
        end
        push(0, "off_after_hold", AXI_DOM_OFF, 1'b0);
        tick();

        // Abort a drain two cycles in
        en[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(0, "rewake", AXI_DOM_WAKE, 1'b0);
            tick();
        end
        push(0, "rewake_active", AXI_DOM_ACTIVE, 1'b0);
        tick();
        en[0] = 1'b0;
        push(0, "abort_drain1", AXI_DOM_DRAIN, 1'b0);
        tick();
        push(0, "abort_drain2", AXI_DOM_DRAIN, 1'b0);
        tick();
        en[0] = 1'b1;
        push(0, "abort_active", AXI_DOM_ACTIVE, 1'b0);
        tick();
        push(0, "abort_stays", AXI_DOM_ACTIVE, 1'b0);
        tick();

        // Asynchronous reset mid-cycle while Active
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) push(d, "async_rst", AXI_DOM_OFF, 1'b0);
        drain_q();
        push(0, "rst_held", AXI_DOM_OFF, 1'b0);
        tick();

        // Wake aborted in its third cycle
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push(0, "wake_partial", AXI_DOM_WAKE, 1'b0);
            tick();
        end
        en[0] = 1'b0;
        push(0, "wake_abort_rsthold", AXI_DOM_RSTHOLD, 1'b0);
        tick();
        for (int i = 1; i <= 15; i++) begin
            push(0, "wake_abort_hold", AXI_DOM_RSTHOLD, 1'b0);
            tick();
        end
        push(0, "wake_abort_off", AXI_DOM_OFF, 1'b0);
        tick();

        // Drain timeout, forced (dut1) versus waiting (dut2)
        en[2:1] = 2'b11;
        for (int i = 1; i <= 8; i++) begin
            push(1, "to_wake", AXI_DOM_WAKE, 1'b0);
            push(2, "to_wake", AXI_DOM_WAKE, 1'b0);
            tick();
        end
        push(1, "to_active", AXI_DOM_ACTIVE, 1'b0);
        push(2, "to_active", AXI_DOM_ACTIVE, 1'b0);
        tick();
        en[2:1] = 2'b00;
        for (int i = 0; i <= 3; i++) begin
            push(1, "to_drain", AXI_DOM_DRAIN, 1'b0);
            push(2, "to_drain", AXI_DOM_DRAIN, 1'b0);
            tick();
        end
        push(1, "to_forced", AXI_DOM_RSTHOLD, 1'b1);
        push(2, "to_waiting", AXI_DOM_DRAIN, 1'b1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            push(1, "to_forced_hold", AXI_DOM_RSTHOLD, 1'b1);
            push(2, "to_saturated", AXI_DOM_DRAIN, 1'b1);
            tick();
        end
        iso[2] = 1'b1;
        push(1, "to_forced_hold", AXI_DOM_RSTHOLD, 1'b1);
        push(2, "to_late_isolate", AXI_DOM_RSTHOLD, 1'b1);
        tick();
        iso[2] = 1'b0;
        for (int i = 5; i <= 15; i++) begin
            push(1, "to_forced_hold", AXI_DOM_RSTHOLD, 1'b1);
            tick();
        end
        push(1, "to_off_sticky", AXI_DOM_OFF, 1'b1);
        tick();
        en[1] = 1'b1;
        push(1, "to_cleared_on_wake", AXI_DOM_WAKE, 1'b0);
        tick();
        for (int i = 2; i <= 8; i++) begin
            push(1, "to_rewake", AXI_DOM_WAKE, 1'b0);
            tick();
        end
        push(1, "to_reactive", AXI_DOM_ACTIVE, 1'b0);
        tick();

        // Isolation arriving on the terminal-count cycle beats the timeout
        en[1] = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            push(1, "race_drain", AXI_DOM_DRAIN, 1'b0);
            tick();
        end
        iso[1] = 1'b1;
        push(1, "race_isolated_wins", AXI_DOM_RSTHOLD, 1'b0);
        tick();
        iso[1] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_domain_ctrl.md
AXI_DOMAIN_CTRL -- requirements
Module: axi_domain_ctrl

Interface
REQ-001 The block SHALL have parameter TimeoutCycles, default 32'd1024, meaning the maximum Drain cycles to wait for isolated_i.
REQ-002 The block SHALL have parameter RstHoldCycles, default 32'd16, meaning the minimum cycles domain_rst_no stays low before the domain may wake.
REQ-003 The block SHALL have parameter WakeCycles, default 32'd8, meaning the cycles between reset release and de-isolation.
REQ-004 The block SHALL have parameter ForceOnTimeout, default 1'b1, meaning that a Drain timeout proceeds to reset instead of waiting forever.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port domain_en_i, input, 1 bit: level request; 1 = domain active.
REQ-008 The block SHALL have port isolated_i, input, 1 bit: from axi_isolate isolated_o.
REQ-009 The block SHALL have port isolate_o, output, 1 bit: to axi_isolate isolate_i.
REQ-010 The block SHALL have port domain_rst_no, output, 1 bit: active-low reset of the downstream domain.
REQ-011 The block SHALL have port active_o, output, 1 bit: high only in Active.
REQ-012 The block SHALL have port timeout_o, output, 1 bit: sticky Drain-timeout flag.
REQ-013 The block SHALL have port state_o, output, 3 bits: current state encoding.

Function
REQ-014 The FSM SHALL have five states: Active=0, Drain=1, RstHold=2, Off=3, Wake=4; the remaining codes are unreachable and SHALL return to Off.
REQ-015 Outputs SHALL be decoded from the registered state only, with no input-to-output combinational path:
- isolate_o = (state != Active)
- domain_rst_no = (state ∈ {Active, Drain, Wake})
- active_o = (state == Active)
REQ-016 In Active, domain_en_i==0 SHALL move the FSM to Drain on the next edge and clear cnt; isolate_o is therefore 1 exactly one cycle after domain_en_i falls.
REQ-017 In Drain, isolated_i==1 SHALL move the FSM to RstHold and clear cnt; this rule has priority over every other Drain rule.
REQ-018 In Drain with isolated_i==0 and domain_en_i==1, the FSM SHALL return to Active (abort).
REQ-019 In Drain with isolated_i==0 and domain_en_i==0, cnt SHALL increment each cycle.
REQ-020 When cnt==TimeoutCycles-1 in Drain, timeout_o SHALL set on the next edge.
- If ForceOnTimeout==1, the FSM SHALL go to RstHold and clear cnt.
- If ForceOnTimeout==0, the FSM SHALL stay in Drain and cnt SHALL saturate.
REQ-021 In RstHold, cnt SHALL increment each cycle; at cnt==RstHoldCycles-1 the FSM SHALL go to Off; domain_en_i is ignored in RstHold.
REQ-022 In Off, domain_en_i==1 SHALL move the FSM to Wake, clear cnt and clear timeout_o.
REQ-023 In Wake, cnt SHALL increment each cycle; at cnt==WakeCycles-1 the FSM SHALL go to Active; domain_en_i==0 in Wake SHALL go directly to RstHold and clear cnt.
REQ-024 cnt SHALL be a single shared counter of width $clog2(max(TimeoutCycles,RstHoldCycles,WakeCycles)+1) and SHALL never wrap.
REQ-025 timeout_o SHALL be set only by REQ-020 and cleared only by REQ-022 or by reset.
REQ-026 Simultaneous events SHALL resolve as follows: isolated_i and timeout in the same Drain cycle resolve as isolated (timeout_o not set); domain_en_i toggles shorter than one cycle SHALL be honoured only if they are sampled.

Reset
REQ-027 While rst_ni==0 the block SHALL be in Off, with cnt=0, isolate_o=1, domain_rst_no=0, active_o=0, timeout_o=0 and state_o=3.
REQ-028 Assertion of rst_ni mid-operation in any state SHALL take effect asynchronously, forcing REQ-027 values immediately; after release, wake-up follows REQ-022.
REQ-029 All flops SHALL use the asynchronous-reset, load-enable register macros of the codebase, with reset value Off.

Structure
REQ-030 The enum axi_domain_state_e (3 bits, codes per REQ-014) SHALL live in axi_pkg so that status registers can decode state_o.
REQ-031 The block SHALL instantiate no sub-module; the counter is inline, since one shared counter with per-state terminal values is simpler than separate counter instances.
REQ-032 Elaboration SHALL fatal if TimeoutCycles, RstHoldCycles or WakeCycles is 0.
REQ-033 The intended use is to pair the block with axi_isolate (isolate_o -> isolate_i, isolated_o -> isolated_i), with domain_rst_no resetting the master-side subordinate.

Verification
REQ-034 Scenario: reset release with domain_en_i=1 at cycle 0, default parameters -> Wake cycles 1-8 (domain_rst_no=1, isolate_o=1), Active from cycle 9 (isolate_o=0, active_o=1).
REQ-035 Scenario: in Active, domain_en_i falls at cycle n and isolated_i rises at n+5 -> Drain at n+1, RstHold at n+6 (domain_rst_no=0), Off at n+22.
REQ-036 Scenario: Drain with isolated_i held 0, TimeoutCycles=4, ForceOnTimeout=1 -> timeout_o=1 and RstHold exactly 4 cycles after Drain entry; with ForceOnTimeout=0 -> timeout_o=1 and the FSM stays in Drain.
REQ-037 Scenario: domain_en_i re-asserted 2 cycles into Drain with isolated_i=0 -> Active on the next edge, domain_rst_no never drops, timeout_o=0.
REQ-038 Scenario: rst_ni pulsed low while in Active -> isolate_o=1 and domain_rst_no=0 in the same cycle as rst_ni falls, state_o=3, timeout_o cleared.
REQ-039 Scenario: domain_en_i falls in Wake cycle 3 -> RstHold next edge, then Off after 16 cycles, and timeout_o stays 0 throughout.
